// File: rtl/seg_pkg.sv
// ============================================================================
// seg_pkg : shared types and constants for the segment display arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam int         NUM_REQ   = 3;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [3:0][7:0] seg_frame_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/segment_rr_pick.sv
// ============================================================================
// segment_rr_pick : combinational round-robin search over three requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module segment_rr_pick
  import seg_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         start,
  output logic               found,
  output logic [1:0]         index
);

  logic [NUM_REQ-1:0] rot;
  logic [1:0]         offset;
  logic [2:0]         sum;

  // Rotate so the first candidate sits at bit 0, then a fixed priority scan
  always_comb begin
    case (start)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
  end

  always_comb begin
    offset = 2'd2;
    if (rot[0])      offset = 2'd0;
    else if (rot[1]) offset = 2'd1;
  end

  always_comb begin
    found = |rot;
    sum   = {1'b0, start} + {1'b0, offset};
    if (sum >= 3'd3) sum = sum - 3'd3;
    index = sum[1:0];
  end

endmodule

`default_nettype wire

// File: rtl/segment_display_arbiter.sv
// ============================================================================
// segment_display_arbiter : round-robin owner of a 4-digit 7-segment display
// with minimum/maximum hold times; registered grant and segment outputs.
// Rev 1.0
// ============================================================================
`default_nettype none

module segment_display_arbiter
  import seg_pkg::*;
#(
  parameter int         MIN_HOLD = 1000,
  parameter int         MAX_HOLD = 50000000,
  parameter logic [7:0] BLANK    = SEG_BLANK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [31:0]        frame0,
  input  logic [31:0]        frame1,
  input  logic [31:0]        frame2,
  output logic [NUM_REQ-1:0] grant,
  output logic [7:0]         segment_data0,
  output logic [7:0]         segment_data1,
  output logic [7:0]         segment_data2,
  output logic [7:0]         segment_data3,
  output logic               busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] MIN_CNT = HOLD_W'(MIN_HOLD);
  localparam logic [HOLD_W-1:0] MAX_CNT = HOLD_W'(MAX_HOLD);

  state_t              state, state_nxt;
  logic [1:0]          owner, owner_nxt;
  logic [1:0]          last_owner, last_owner_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  seg_frame_t          segs, segs_nxt;
  logic [NUM_REQ-1:0]  grant_nxt;

  logic [NUM_REQ-1:0]  owner_bit;
  logic                owner_req;
  logic                others_req;
  logic                release_now;
  logic [1:0]          pick_base;
  logic [1:0]          pick_start;
  logic [NUM_REQ-1:0]  pick_req;
  logic                pick_found;
  logic [1:0]          pick_idx;
  seg_frame_t          sel_frame;

  assign owner_bit  = idx_onehot(owner);
  assign owner_req  = |(req & owner_bit);
  assign others_req = |(req & ~owner_bit);

  assign release_now = (state == OWNED) && (hold_cnt >= MIN_CNT) &&
                       (!owner_req || ((hold_cnt >= MAX_CNT) && others_req));

  // The outgoing owner is masked so a release always hands to someone else
  assign pick_base  = (state == OWNED) ? owner : last_owner;
  assign pick_start = (pick_base == 2'd2) ? 2'd0 : pick_base + 2'd1;
  assign pick_req   = (state == OWNED) ? (req & ~owner_bit) : req;

  segment_rr_pick u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .index (pick_idx)
  );

  // State register (also captures the registered outputs)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd2;
      hold_cnt   <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      segs       <= {4{BLANK}};
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      hold_cnt   <= hold_cnt_nxt;
      grant      <= grant_nxt;
      busy       <= |grant_nxt;
      segs       <= segs_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    hold_cnt_nxt   = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt    = OWNED;
          owner_nxt    = pick_idx;
          hold_cnt_nxt = HOLD_W'(1);
        end
      end
      OWNED: begin
        if (release_now) begin
          last_owner_nxt = owner;
          if (pick_found) begin
            owner_nxt    = pick_idx;
            hold_cnt_nxt = HOLD_W'(1);
          end else begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
          end
        end else if (hold_cnt < MAX_CNT) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (owner_nxt)
      2'd1:    sel_frame = frame1;
      2'd2:    sel_frame = frame2;
      default: sel_frame = frame0;
    endcase
  end

  // Output logic: a fresh grant or a requesting owner loads; otherwise freeze
  always_comb begin
    grant_nxt = '0;
    segs_nxt  = {4{BLANK}};
    if (state_nxt == OWNED) begin
      grant_nxt = idx_onehot(owner_nxt);
      if (state != OWNED || owner_nxt != owner || owner_req)
        segs_nxt = sel_frame;
      else
        segs_nxt = segs;
    end
  end

  assign segment_data0 = segs[0];
  assign segment_data1 = segs[1];
  assign segment_data2 = segs[2];
  assign segment_data3 = segs[3];

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant))
    else $error("grant is multi-hot: %b", grant);

endmodule

`default_nettype wire
